// File: rtl/elevator_scheduler.sv
// SCAN call scheduler and motion sequencer for an elevator car.
// The optional ELEV_HOME_RETURN_EN build adds an idle timer that recalls the car to floor 0.
module elevator_scheduler #(
  parameter int unsigned NUM_FLOORS   = 4,
  parameter int unsigned MOVE_CYCLES  = 8,
  parameter int unsigned DOOR_CYCLES  = 6,
  parameter int unsigned HOME_TIMEOUT = 64,
  localparam int unsigned FW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] req,
  output logic [FW-1:0]         floor,
  output logic                  dir,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  served,
  output logic [FW-1:0]         served_floor
);

  localparam int unsigned MCW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int unsigned DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StMove, StDoor} state_e;

  state_e                  state;
  logic [MCW-1:0]          step_cnt;
  logic [DCW-1:0]          door_cnt;
  logic                    up_any;
  logic                    dn_any;
  logic [FW-1:0]           next_floor;
  logic [NUM_FLOORS-1:0]   cur_bit;
  logic [NUM_FLOORS-1:0]   next_bit;
  logic [NUM_FLOORS-1:0]   home_set;
  logic [NUM_FLOORS-1:0]   pend_in;
  logic                    step_done;
  logic                    door_done;

`ifdef ELEV_HOME_RETURN_EN
  localparam int unsigned HW = $clog2(HOME_TIMEOUT + 1);
  logic [HW-1:0] idle_cnt;
  logic          idle_cond;
  logic          home_hit;

  assign idle_cond = (state == StIdle) && (pending == '0) && (floor != '0);
  assign home_hit  = idle_cond && (idle_cnt == HW'(HOME_TIMEOUT - 1));
  assign home_set  = {{(NUM_FLOORS-1){1'b0}}, home_hit};

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (idle_cond && !home_hit) begin
      idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  assign home_set = '0;
`endif

  // Calls strictly above / below the car, from registered pending only.
  always_comb begin
    up_any = 1'b0;
    dn_any = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (i > int'(floor))) up_any = 1'b1;
      if (pending[i] && (i < int'(floor))) dn_any = 1'b1;
    end
  end

  assign next_floor = dir ? (floor - FW'(1)) : (floor + FW'(1));
  assign cur_bit    = NUM_FLOORS'(1) << floor;
  assign next_bit   = NUM_FLOORS'(1) << next_floor;
  assign pend_in    = pending | req | home_set;
  assign step_done  = (step_cnt == MCW'(MOVE_CYCLES - 1));
  assign door_done  = (door_cnt == DCW'(DOOR_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      floor        <= '0;
      dir          <= 1'b0;
      moving       <= 1'b0;
      door_open    <= 1'b0;
      pending      <= '0;
      served       <= 1'b0;
      served_floor <= '0;
      step_cnt     <= '0;
      door_cnt     <= '0;
    end else begin
      served  <= 1'b0;
      pending <= pend_in;
      case (state)
        StIdle: begin
          if (pending[floor]) begin
            state        <= StDoor;
            door_open    <= 1'b1;
            served       <= 1'b1;
            served_floor <= floor;
            door_cnt     <= '0;
            pending      <= pend_in & ~cur_bit;
          end else if (dir ? dn_any : up_any) begin
            state    <= StMove;
            moving   <= 1'b1;
            step_cnt <= '0;
          end else if (dir ? up_any : dn_any) begin
            dir      <= ~dir;
            state    <= StMove;
            moving   <= 1'b1;
            step_cnt <= '0;
          end
        end
        StMove: begin
          if (step_done) begin
            step_cnt <= '0;
            floor    <= next_floor;
            // Arrival stop also honours a call raised on the arrival edge itself.
            if ((pend_in & next_bit) != '0) begin
              state        <= StDoor;
              moving       <= 1'b0;
              door_open    <= 1'b1;
              served       <= 1'b1;
              served_floor <= next_floor;
              door_cnt     <= '0;
              pending      <= pend_in & ~next_bit;
            end
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        StDoor: begin
          pending <= pend_in & ~cur_bit;
          if (req[floor]) begin
            door_cnt <= '0;
          end else if (door_done) begin
            state     <= StIdle;
            door_open <= 1'b0;
            door_cnt  <= '0;
          end else begin
            door_cnt <= door_cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios plus random calls, every cycle compared
// against a countdown-based behavioural model of the car.
module tb_elevator_scheduler;

  localparam int NF = 4;
  localparam int MC = 4;
  localparam int DC = 3;
  localparam int HT = 10;

  logic          clk;
  logic          rst;
  logic [NF-1:0] req;
  logic [1:0]    floor;
  logic          dir;
  logic          moving;
  logic          door_open;
  logic [NF-1:0] pending;
  logic          served;
  logic [1:0]    served_floor;

  int checks;
  int failures;

  // Model state: mode 0=idle 1=travelling 2=doors open
  int       m_mode;
  int       m_floor;
  int       m_dir;
  int       m_left;
  int       m_idle;
  int       m_sfloor;
  logic     m_served;
  logic [NF-1:0] m_pend;

  elevator_scheduler #(
    .NUM_FLOORS  (NF),
    .MOVE_CYCLES (MC),
    .DOOR_CYCLES (DC),
    .HOME_TIMEOUT(HT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .floor       (floor),
    .dir         (dir),
    .moving      (moving),
    .door_open   (door_open),
    .pending     (pending),
    .served      (served),
    .served_floor(served_floor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit calls_toward(input int d);
    bit any = 0;
    for (int f = 0; f < NF; f++) begin
      if (m_pend[f] && ((d == 0 && f > m_floor) || (d == 1 && f < m_floor))) any = 1;
    end
    return any;
  endfunction

  task automatic open_doors(input int f);
    m_mode   = 2;
    m_left   = DC;
    m_served = 1'b1;
    m_sfloor = f;
  endtask

  task automatic model_step(input logic [NF-1:0] r, input logic rs);
    logic [NF-1:0] np;
    if (rs) begin
      m_mode = 0; m_floor = 0; m_dir = 0; m_pend = '0; m_served = 1'b0;
      m_sfloor = 0; m_left = 0; m_idle = 0;
    end else begin
      np = m_pend | r;
      m_served = 1'b0;
      if (m_mode == 0) begin
        if (m_pend[m_floor]) begin
          open_doors(m_floor);
          np[m_floor] = 1'b0;
          m_idle = 0;
        end else if (calls_toward(m_dir)) begin
          m_mode = 1; m_left = MC; m_idle = 0;
        end else if (calls_toward(1 - m_dir)) begin
          m_dir = 1 - m_dir; m_mode = 1; m_left = MC; m_idle = 0;
        end else if (m_floor != 0) begin
          m_idle++;
`ifdef ELEV_HOME_RETURN_EN
          if (m_idle == HT) begin
            np[0] = 1'b1;
            m_idle = 0;
          end
`endif
        end else begin
          m_idle = 0;
        end
      end else if (m_mode == 1) begin
        m_idle = 0;
        m_left--;
        if (m_left == 0) begin
          m_floor = (m_dir == 0) ? m_floor + 1 : m_floor - 1;
          m_left = MC;
          if (np[m_floor]) begin
            open_doors(m_floor);
            np[m_floor] = 1'b0;
          end
        end
      end else begin
        m_idle = 0;
        np[m_floor] = 1'b0;
        if (r[m_floor]) m_left = DC;
        else begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      end
      m_pend = np;
    end
  endtask

  task automatic tick(input logic [NF-1:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    model_step(r, rs);
    #1;
    chk("floor", 32'(floor), 32'(m_floor));
    chk("dir", 32'(dir), 32'(m_dir));
    chk("moving", 32'(moving), 32'(m_mode == 1));
    chk("door_open", 32'(door_open), 32'(m_mode == 2));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("served", 32'(served), 32'(m_served));
    chk("served_floor", 32'(served_floor), 32'(m_sfloor));
  endtask

  task automatic wait_served(input string tag, input int budget, input int exp_floor);
    for (int i = 0; i < budget; i++) begin
      tick('0, 1'b0);
      if (served) break;
    end
    chk({tag, "_served"}, 32'(served), 32'd1);
    chk({tag, "_served_floor"}, 32'(served_floor), 32'(exp_floor));
  endtask

  task automatic wait_closed(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!door_open) break;
      tick('0, 1'b0);
    end
    chk({tag, "_closed"}, 32'(door_open), 32'd0);
  endtask

  initial begin
    logic saw_home;
    logic [NF-1:0] r;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    req = '0;

    // 1: single call to floor 2
    tick('0, 1'b1);
    chk("t1_reset_floor", 32'(floor), 32'd0);
    chk("t1_reset_pending", 32'(pending), 32'd0);
    tick(4'b0100, 1'b0);
    chk("t1_not_yet_moving", 32'(moving), 32'd0);
    tick('0, 1'b0);
    chk("t1_moving", 32'(moving), 32'd1);
    wait_served("t1", 20, 2);
    tick('0, 1'b0);
    tick('0, 1'b0);
    chk("t1_door_third", 32'(door_open), 32'd1);
    tick('0, 1'b0);
    chk("t1_door_done", 32'(door_open), 32'd0);
    chk("t1_pending", 32'(pending), 32'd0);

    // 2: intermediate stop picked up on the way to 3
    tick('0, 1'b1);
    tick(4'b1000, 1'b0);
    tick('0, 1'b0);
    tick('0, 1'b0);
    tick('0, 1'b0);
    tick(4'b0010, 1'b0);
    wait_served("t2_first", 3, 1);
    wait_served("t2_second", 40, 3);
    wait_closed("t2", 10);

    // 3: car at 2 heading up, calls at 0 and 3
    tick('0, 1'b1);
    tick(4'b0100, 1'b0);
    wait_served("t3_park", 20, 2);
    wait_closed("t3_park", 10);
    tick(4'b1001, 1'b0);
    wait_served("t3_up", 20, 3);
    chk("t3_dir_up", 32'(dir), 32'd0);
    wait_served("t3_down", 40, 0);
    chk("t3_dir_down", 32'(dir), 32'd1);
    wait_closed("t3", 10);

    // 4: call at current floor, then reopen
    tick('0, 1'b1);
    tick(4'b0010, 1'b0);
    wait_served("t4_park", 20, 1);
    wait_closed("t4_park", 10);
    tick(4'b0010, 1'b0);
    wait_served("t4_open", 3, 1);
    tick('0, 1'b0);
    tick(4'b0010, 1'b0);
    tick('0, 1'b0);
    tick('0, 1'b0);
    chk("t4_reopen_held", 32'(door_open), 32'd1);
    tick('0, 1'b0);
    chk("t4_reopen_closed", 32'(door_open), 32'd0);
    chk("t4_floor", 32'(floor), 32'd1);

    // 5: reset between floors 1 and 2
    tick('0, 1'b1);
    tick(4'b1000, 1'b0);
    for (int i = 0; i < MC + 3; i++) tick('0, 1'b0);
    chk("t5_floor_mid", 32'(floor), 32'd1);
    chk("t5_pending_mid", 32'(pending), 32'h8);
    tick('0, 1'b1);
    chk("t5_floor", 32'(floor), 32'd0);
    chk("t5_moving", 32'(moving), 32'd0);
    chk("t5_pending", 32'(pending), 32'd0);
    tick('0, 1'b0);
    chk("t5_stays", 32'(moving), 32'd0);

    // 6: parked at 3, home return only when enabled
    tick('0, 1'b1);
    tick(4'b1000, 1'b0);
    wait_served("t6_park", 40, 3);
    wait_closed("t6_park", 10);
    saw_home = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick('0, 1'b0);
      if (served && served_floor == 2'd0) saw_home = 1'b1;
    end
`ifdef ELEV_HOME_RETURN_EN
    chk("t6_homed", 32'(saw_home), 32'd1);
    chk("t6_floor", 32'(floor), 32'd0);
`else
    chk("t6_parked", 32'(saw_home), 32'd0);
    chk("t6_floor", 32'(floor), 32'd3);
`endif

    // Random calls with occasional resets
    tick('0, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 5) == 0) ? NF'($urandom) : '0;
      tick(r, $urandom_range(0, 399) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
